// File: rtl/uart_tx.sv
// uart_tx: transmit-only 8N1 asynchronous serial transmitter, LSB first.
// Ports: clock, reset (async, active high), send, byte_to_send[7:0] in;
//        done (idle and no send pending), pin (registered serial line) out.
// Option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx #(
    parameter int clocks_per_bit = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] byte_to_send,
    output logic       done,
    output logic       pin
);

    localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      bit_q, bit_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            pin_q, pin_d;
    logic            last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            pin_q   <= pin_d;
        end
    end

    assign last = (cyc_q == LAST);

    // pin_d is the line level for the bit that begins after this edge,
    // which keeps pin registered while the start bit still appears one
    // cycle after the accepting edge.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q + CW'(1);
        pin_d   = pin_q;
        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
                pin_d = 1'b1;
                if (send) begin
                    state_d = START;
                    data_d  = byte_to_send;
                    pin_d   = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                    pin_d   = data_q[0];
                end
            end
            DATA: begin
                if (last) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        pin_d   = ^data_q;
`else
                        state_d = STOP;
                        pin_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        pin_d = data_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_d = STOP;
                    cyc_d   = '0;
                    pin_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    pin_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                pin_d   = 1'b1;
            end
        endcase
    end

    assign pin  = pin_q;
    assign done = (state_q == IDLE) && !send;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + randomized bench for uart_tx at clocks_per_bit 1 and 4.
// Expected line levels come from a frame model built from the byte value.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send_s [2];
    logic [7:0] byte_s [2];
    logic       done_w [2];
    logic       pin_w  [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx #(.clocks_per_bit(1)) dut1 (
        .clock(clock), .reset(reset), .send(send_s[0]),
        .byte_to_send(byte_s[0]), .done(done_w[0]), .pin(pin_w[0])
    );

    uart_tx #(.clocks_per_bit(4)) dut4 (
        .clock(clock), .reset(reset), .send(send_s[1]),
        .byte_to_send(byte_s[1]), .done(done_w[1]), .pin(pin_w[1])
    );

    // Frame as transmitted on the line, index 0 first.
    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        int ones;
        ones = 0;
        f = '0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = b[k];
            ones += int'(b[k]);
        end
`ifdef UART_TX_PARITY_EN
        f[9] = (ones % 2) == 1;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called in an idle cycle just after a negedge; returns likewise.
    // mode 0: quiet, 1: random send/byte noise, 2: 0x55 pulse mid-frame.
    task automatic xfer(input int d, input logic [7:0] b, input int mode);
        int cpb;
        int len;
        logic [NB-1:0] f;
        cpb = (d == 0) ? 1 : 4;
        len = NB * cpb;
        f = frame_of(b);
        byte_s[d] = b;
        send_s[d] = 1'b1;
        #1;
        check($sformatf("d%0d done_drop %h", d, b), done_w[d], 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            check($sformatf("d%0d byte %h cyc %0d", d, b, i),
                  pin_w[d], f[i / cpb]);
            check($sformatf("d%0d busy %h cyc %0d", d, b, i),
                  done_w[d], 1'b0);
            send_s[d] = 1'b0;
            if (mode == 1) begin
                byte_s[d] = 8'($urandom);
                send_s[d] = 1'($urandom);
            end else if (mode == 2 && i == len / 2) begin
                byte_s[d] = 8'h55;
                send_s[d] = 1'b1;
            end
        end
        @(negedge clock);
        send_s[d] = 1'b0;
        #1;
        check($sformatf("d%0d done_end %h", d, b), done_w[d], 1'b1);
        check($sformatf("d%0d idle_pin %h", d, b), pin_w[d], 1'b1);
    endtask

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'hFF;
        seq[1] = 8'hFD;
        seq[2] = 8'h00;
        for (int d = 0; d < 2; d++) begin
            send_s[d] = 1'b0;
            byte_s[d] = 8'h00;
        end

        repeat (3) @(negedge clock);
        #1;
        check("rst_pin0", pin_w[0], 1'b1);
        check("rst_pin1", pin_w[1], 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("idle d%0d pin %0d", d, i), pin_w[d], 1'b1);
                check($sformatf("idle d%0d done %0d", d, i), done_w[d], 1'b1);
            end
        end

        xfer(0, 8'hA5, 0);
        xfer(1, 8'h0F, 0);

        for (int i = 0; i < 3; i++) xfer(0, seq[i], 1);
        for (int i = 0; i < 3; i++) xfer(1, seq[i], 1);

        xfer(0, 8'h33, 2);
        xfer(1, 8'h33, 2);

        for (int i = 0; i < 6; i++) xfer(0, 8'($urandom), 1);
        for (int i = 0; i < 3; i++) xfer(1, 8'($urandom), 1);

`ifdef UART_TX_PARITY_EN
        xfer(0, 8'h07, 0);
        xfer(0, 8'h03, 0);
        xfer(1, 8'h07, 0);
`endif

        // Abort during data bit 3 of a clocks_per_bit=4 frame.
        byte_s[1] = 8'h00;
        send_s[1] = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            @(negedge clock);
            send_s[1] = 1'b0;
        end
        check("pre_abort_pin", pin_w[1], 1'b0);
        reset = 1'b1;
        #1;
        check("abort_pin", pin_w[1], 1'b1);
        check("abort_done", done_w[1], 1'b1);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("post_abort pin %0d", i), pin_w[1], 1'b1);
            check($sformatf("post_abort done %0d", i), done_w[1], 1'b1);
        end

        xfer(1, 8'hC3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
